i_cache: RTL and testbench
==========================

// Module: i_cache
// PURPOSE
//  Direct-mapped instruction cache: the responder side of the fetcher's icache port.
//  Takes the fetch PC and returns the instruction at that PC: a full 32-bit word, or a
//    16-bit RVC parcel zero-extended to 32 bits.
//  Fetches missing words from the memory controller over a word-wide req/ready port.
//  Handles halfword-aligned PCs, including 32-bit instructions that straddle two words.
// PARAMETERS
//  INDEX_BITS  8  log2 of word entries (default 256 x 32b); tag = PC[31:INDEX_BITS+2]
// PORTS
//  clk_in     in   1   system clock
//  rst_in     in   1   asynchronous, active-low reset
//  rdy_in     in   1   low: freeze all state and outputs
//  fetch_pc   in   32  PC requested by fetcher (bit0 ignored)
//  fetch_able in   1   fetcher wants an instruction
//  clear      in   1   fetcher PC redirect (branch reset / jalr resolve)
//  ins_ready  out  1   one-cycle pulse: ins/ins_pc valid
//  ins        out  32  instruction; RVC -> {16'b0, parcel}
//  ins_pc     out  32  PC of ins, {fetch_pc[31:1],1'b0}
//  mem_req    out  1   word read request to memory controller
//  mem_addr   out  32  word address, [1:0]=00
//  mem_ready  in   1   mem_data valid this cycle; completes request
//  mem_data   in   32  returned word
// BEHAVIOUR
//  Reset (rst_in=0, async): all valid bits 0, state IDLE, every output 0.
//  rdy_in=0: no register changes; mem_req/mem_addr hold.
//  Lookup addresses: w0 = {pc[31:2],2'b00}; w1 = w0+4 (mod 2^32; 0xFFFFFFFC -> 0).
//  Assembly:
//    pc[1]=0 -> parcel = w0[15:0]; if parcel[1:0]==11, ins=w0; else {16'b0, parcel}.
//    pc[1]=1 -> parcel = w0[31:16]; if parcel[1:0]!=11, ins={16'b0, parcel};
//      else ins={w1[15:0], parcel}. w1 is needed only in this case.
//  States: IDLE, FILL.
//  IDLE, per edge, with fetch_able=1, clear=0 and ins_ready currently 0:
//    - All needed words hit: next cycle ins_ready=1, ins/ins_pc loaded.
//    - Otherwise: mem_req<=1, mem_addr<=first missing word (w0 before w1), go to FILL.
//    - Otherwise idle: ins_ready<=0.
//    - After any pulse, ins_ready drops for >=1 cycle. Peak rate is 1 instruction per
//      2 cycles, so the fetcher can update its PC before the next lookup.
//  FILL: mem_addr stable while mem_req=1.
//    - On edge with mem_ready=1: write mem_data, set valid/tag at that index
//      (evicting the previous occupant); mem_req<=0; state<=IDLE.
//    - IDLE re-looks up, so a straddle miss costs two fills.
//  clear=1: ins_ready<=0 at that edge, no lookup that cycle.
//    - In FILL, the memory transaction is not aborted: the fill completes and is
//      written, but produces no output by itself.
//  fetch_able=0: no new lookup/pulse; an ongoing FILL still completes.
//  A pulse ignored by the fetcher (stall) is repeated every 2 cycles while fetch_able=1.
//  Hit latency: 1 edge. Miss: 2 edges after the mem_ready edge.
//  Precedence: reset > rdy_in=0 > clear > normal.
// TESTING
//  1. rst_in low mid-FILL -> mem_req=0, ins_ready=0; after release, pc=0 misses again (valid cleared).
//  2. Cold miss pc=0, mem returns 32'h00000513 three cycles after req ->
//     mem_addr=0; ins_ready pulse 2 edges after mem_ready, ins=32'h00000513, ins_pc=0.
//  3. RVC: w0@0x0 = 32'h45010513 cached, pc=2 -> ins=32'h00004501, ins_pc=2, no mem_req.
//  4. Straddle: pc=0x102, mem@0x100 = 32'h0513_0001, mem@0x104 = 32'h1234_0000 ->
//     fills 0x100 then 0x104; ins=32'h00000513.
//  5. Conflict (INDEX_BITS=8): fetch 0x0, then 0x400, then 0x0 -> three fills; third re-requests 0x0.
//  6. clear asserted during FILL (and rdy_in low 2 cycles) -> no ins_ready, fill completes;
//     next lookup of the same pc hits with no mem_req.

Source files
------------

// File: rtl/i_cache.sv
// Direct-mapped instruction cache answering the fetcher's icache port. Assembles full words
// or zero-extended RVC parcels from halfword-aligned PCs, filling misses one word at a time.
module i_cache #(
    parameter int INDEX_BITS = 8
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] fetch_pc,
    input  logic        fetch_able,
    input  logic        clear,
    output logic        ins_ready,
    output logic [31:0] ins,
    output logic [31:0] ins_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_data
);
    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_W   = 30 - INDEX_BITS;

    typedef enum logic {IDLE, FILL} state_t;

    state_t             state_q, state_d;
    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q  [ENTRIES];
    logic [31:0]        data_q [ENTRIES];

    logic        ins_ready_q, ins_ready_d;
    logic [31:0] ins_q, ins_d;
    logic [31:0] ins_pc_q, ins_pc_d;
    logic        mem_req_q, mem_req_d;
    logic [31:0] mem_addr_q, mem_addr_d;

    logic [31:0]           w0, w1, word0, assembled;
    logic [INDEX_BITS-1:0] idx0, idx1, fill_idx;
    logic [15:0]           parcel, word1_lo;
    logic                  hit0, hit1, is32, need_w1, all_hit, fill_en;
    logic                  unused_pc0;

    assign unused_pc0 = fetch_pc[0];

    // w1 wraps naturally at the top of the address space
    assign w0       = {fetch_pc[31:2], 2'b00};
    assign w1       = w0 + 32'd4;
    assign idx0     = w0[INDEX_BITS+1:2];
    assign idx1     = w1[INDEX_BITS+1:2];
    assign hit0     = valid_q[idx0] && (tag_q[idx0] == w0[31:INDEX_BITS+2]);
    assign hit1     = valid_q[idx1] && (tag_q[idx1] == w1[31:INDEX_BITS+2]);
    assign word0    = data_q[idx0];
    assign word1_lo = data_q[idx1][15:0];

    assign parcel    = fetch_pc[1] ? word0[31:16] : word0[15:0];
    assign is32      = (parcel[1:0] == 2'b11);
    assign need_w1   = fetch_pc[1] && is32;
    assign all_hit   = hit0 && (!need_w1 || hit1);
    assign assembled = !is32 ? {16'h0000, parcel}
                     : (fetch_pc[1] ? {word1_lo, parcel} : word0);

    assign fill_en  = rdy_in && (state_q == FILL) && mem_ready;
    assign fill_idx = mem_addr_q[INDEX_BITS+1:2];

    always_comb begin
        state_d     = state_q;
        ins_ready_d = ins_ready_q;
        ins_d       = ins_q;
        ins_pc_d    = ins_pc_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        if (rdy_in) begin
            ins_ready_d = 1'b0;
            case (state_q)
                IDLE: begin
                    // Skipping the lookup right after a pulse gives the fetcher a cycle to move its PC
                    if (!clear && fetch_able && !ins_ready_q) begin
                        if (all_hit) begin
                            ins_ready_d = 1'b1;
                            ins_d       = assembled;
                            ins_pc_d    = {fetch_pc[31:1], 1'b0};
                        end else begin
                            mem_req_d  = 1'b1;
                            mem_addr_d = hit0 ? w1 : w0;
                            state_d    = FILL;
                        end
                    end
                end
                FILL: begin
                    if (mem_ready) begin
                        mem_req_d = 1'b0;
                        state_d   = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= IDLE;
            ins_ready_q <= 1'b0;
            ins_q       <= '0;
            ins_pc_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            ins_ready_q <= ins_ready_d;
            ins_q       <= ins_d;
            ins_pc_q    <= ins_pc_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            valid_q <= '0;
        end else if (fill_en) begin
            valid_q[fill_idx] <= 1'b1;
        end
    end

    // Storage arrays need no reset: valid_q gates every use
    always_ff @(posedge clk_in) begin
        if (fill_en) begin
            data_q[fill_idx] <= mem_data;
            tag_q[fill_idx]  <= mem_addr_q[31:INDEX_BITS+2];
        end
    end

    assign ins_ready = ins_ready_q;
    assign ins       = ins_q;
    assign ins_pc    = ins_pc_q;
    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;
endmodule

// File: tb/tb_i_cache.sv
// Bench for i_cache: a word-addressed memory and a direct-mapped cache model predict
// each instruction and the exact fill sequence; a negedge monitor checks outputs every cycle.
module tb_i_cache;
    localparam int IB = 8;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, fetch_able, clear, mem_ready;
    logic [31:0] fetch_pc, mem_data;
    logic        ins_ready, mem_req;
    logic [31:0] ins, ins_pc, mem_addr;

    i_cache #(.INDEX_BITS(IB)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .fetch_pc(fetch_pc),
        .fetch_able(fetch_able), .clear(clear), .ins_ready(ins_ready), .ins(ins),
        .ins_pc(ins_pc), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready),
        .mem_data(mem_data)
    );

    always #5 clk_in = ~clk_in;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Reference memory (lazily randomised) and direct-mapped cache contents
    logic [31:0] mem_m   [logic [31:0]];
    logic [31:0] cl_addr [int];
    logic [31:0] cl_data [int];

    function automatic logic [31:0] rd(input logic [31:0] a);
        logic [31:0] v;
        if (!mem_m.exists(a)) begin
            v = $urandom;
            if ($urandom_range(0, 1) == 1) v[1:0] = 2'b11;
            if ($urandom_range(0, 1) == 1) v[17:16] = 2'b11;
            mem_m[a] = v;
        end
        return mem_m[a];
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        return int'(a[IB+1:2]);
    endfunction

    function automatic bit m_has(input logic [31:0] a);
        return cl_addr.exists(idx_of(a)) && (cl_addr[idx_of(a)] == a);
    endfunction

    function automatic void m_fill(input logic [31:0] a);
        cl_addr[idx_of(a)] = a;
        cl_data[idx_of(a)] = rd(a);
    endfunction

    // Expectations written by the driver, observations written by the monitor
    logic [31:0] exp_ins = '0, exp_pc = '0;
    bit          exp_valid = 1'b0;
    int          pulse_cnt = 0, pulse_cyc = 0, acc_cyc = 0;
    logic [31:0] got_ins = '0;
    logic [31:0] fillq[$];
    logic        prev_ins = 1'b0, prev_req = 1'b0;
    logic [31:0] prev_addr = '0;

    always @(negedge clk_in) begin
        if (rst_in) begin
            if (ins_ready) begin
                check("pulse_gap", 32'(prev_ins), 32'd0);
                check("pulse_allowed", 32'(exp_valid), 32'd1);
                check("ins", ins, exp_ins);
                check("ins_pc", ins_pc, exp_pc);
                pulse_cnt++;
                pulse_cyc = cyc;
                got_ins = ins;
            end
            if (mem_req && prev_req) check("mem_addr_stable", mem_addr, prev_addr);
            if (mem_req && !prev_req) begin
                fillq.push_back(mem_addr);
                check("mem_addr_align", 32'(mem_addr[1:0]), 32'd0);
            end
            if (mem_req && mem_ready && rdy_in) acc_cyc = cyc;
            prev_ins  = ins_ready;
            prev_req  = mem_req;
            prev_addr = mem_addr;
        end else begin
            prev_ins = 1'b0;
            prev_req = 1'b0;
            prev_addr = '0;
        end
    end

    // Memory controller: answers after mem_dly cycles, holds mem_ready until accepted
    int mem_dly = 2;
    bit mem_hold = 1'b0;
    initial begin
        int cnt;
        cnt = 0;
        mem_ready = 1'b0;
        mem_data = '0;
        forever begin
            @(posedge clk_in);
            #1;
            if (!rst_in) begin
                mem_ready = 1'b0;
                cnt = 0;
            end else if (mem_ready) begin
                if (!mem_req) mem_ready = 1'b0;
            end else if (mem_req && !mem_hold) begin
                if (cnt >= mem_dly) begin
                    mem_ready = 1'b1;
                    mem_data = rd(mem_addr);
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        step();
        fetch_able = 1'b0;
        clear = 1'b0;
        exp_valid = 1'b0;
    endtask

    task automatic do_reset();
        step();
        rst_in = 1'b0;
        cl_addr.delete();
        cl_data.delete();
        exp_valid = 1'b0;
        fetch_able = 1'b0;
        clear = 1'b0;
        mem_hold = 1'b0;
        step();
        step();
        rst_in = 1'b1;
    endtask

    task automatic fetch(input logic [31:0] pc);
        logic [31:0] pf[$];
        logic [31:0] w0, w1, d0, d1, e;
        int pb, fb, dcyc;
        bit got;
        w0 = {pc[31:2], 2'b00};
        w1 = w0 + 32'd4;
        if (!m_has(w0)) begin m_fill(w0); pf.push_back(w0); end
        d0 = cl_data[idx_of(w0)];
        if (!pc[1]) begin
            e = (d0[1:0] == 2'b11) ? d0 : {16'h0000, d0[15:0]};
        end else if (d0[17:16] != 2'b11) begin
            e = {16'h0000, d0[31:16]};
        end else begin
            if (!m_has(w1)) begin m_fill(w1); pf.push_back(w1); end
            d1 = cl_data[idx_of(w1)];
            e = {d1[15:0], d0[31:16]};
        end
        step();
        pb = pulse_cnt;
        fb = fillq.size();
        exp_ins = e;
        exp_pc = {pc[31:1], 1'b0};
        exp_valid = 1'b1;
        fetch_pc = pc;
        fetch_able = 1'b1;
        dcyc = cyc;
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk_in);
            #1;
            if (pulse_cnt != pb) got = 1'b1;
        end
        check("pulse_seen", 32'(got), 32'd1);
        if (got) begin
            check("fill_count", 32'(fillq.size() - fb), 32'(pf.size()));
            if (fillq.size() - fb == pf.size())
                foreach (pf[i]) check("fill_addr", fillq[fb + i], pf[i]);
            if (pf.size() == 0) check("hit_latency", 32'(pulse_cyc - dcyc), 32'd1);
            else                check("miss_latency", 32'(pulse_cyc - acc_cyc), 32'd2);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pb, fb;
        bit got;
        logic [31:0] pc;
        rst_in = 1'b0;
        rdy_in = 1'b1;
        fetch_pc = '0;
        fetch_able = 1'b0;
        clear = 1'b0;
        #12;
        check("rst_ins_ready", 32'(ins_ready), 32'd0);
        check("rst_ins", ins, 32'd0);
        check("rst_ins_pc", ins_pc, 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        step();
        rst_in = 1'b1;

        // Cold miss at pc 0 with a three-cycle memory
        mem_m[32'h0] = 32'h00000513;
        mem_dly = 3;
        fb = fillq.size();
        fetch(32'h0);
        check("cold_ins", got_ins, 32'h00000513);
        check("cold_fill_addr", fillq[fb], 32'h0);

        // Reset in the middle of a fill clears everything
        idle();
        mem_hold = 1'b1;
        fetch_pc = 32'h80;
        fetch_able = 1'b1;
        for (int i = 0; i < 10 && !mem_req; i++) step();
        step();
        step();
        rst_in = 1'b0;
        #2;
        check("midfill_rst_mem_req", 32'(mem_req), 32'd0);
        check("midfill_rst_ins_ready", 32'(ins_ready), 32'd0);
        check("midfill_rst_mem_addr", mem_addr, 32'd0);
        cl_addr.delete();
        cl_data.delete();
        fetch_able = 1'b0;
        step();
        rst_in = 1'b1;
        mem_hold = 1'b0;
        fb = fillq.size();
        fetch(32'h0);
        check("rst_refill_addr", fillq[fb], 32'h0);

        // RVC parcel from the upper half of a cached word
        do_reset();
        mem_m[32'h0] = 32'h45010513;
        fetch(32'h0);
        check("w0_full_ins", got_ins, 32'h45010513);
        fetch(32'h2);
        check("rvc_ins", got_ins, 32'h00004501);

        // 32-bit instruction straddling two words
        mem_m[32'h100] = 32'h05130001;
        mem_m[32'h104] = 32'h12340000;
        fetch(32'h102);
        check("straddle_ins", got_ins, 32'h00000513);
        check("straddle_fill0", fillq[fillq.size() - 2], 32'h100);
        check("straddle_fill1", fillq[fillq.size() - 1], 32'h104);

        // Index conflict between 0x0 and 0x400
        do_reset();
        fb = fillq.size();
        fetch(32'h0);
        fetch(32'h400);
        fetch(32'h0);
        check("conflict_fills", 32'(fillq.size() - fb), 32'd3);
        check("conflict_refetch", fillq[fillq.size() - 1], 32'h0);

        // Redirect plus a freeze during a fill: no pulse, fill still lands
        idle();
        mem_dly = 6;
        pb = pulse_cnt;
        fb = fillq.size();
        fetch_pc = 32'h200;
        fetch_able = 1'b1;
        for (int i = 0; i < 20 && !mem_req; i++) begin
            @(negedge clk_in);
            #1;
        end
        step();
        clear = 1'b1;
        fetch_able = 1'b0;
        step();
        clear = 1'b0;
        rdy_in = 1'b0;
        step();
        step();
        rdy_in = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk_in);
            #1;
            if (!mem_req) got = 1'b1;
        end
        check("clear_fill_done", 32'(got), 32'd1);
        repeat (4) step();
        check("clear_no_pulse", 32'(pulse_cnt - pb), 32'd0);
        check("clear_fill_count", 32'(fillq.size() - fb), 32'd1);
        m_fill(32'h200);
        mem_dly = 1;
        fetch(32'h200);

        // Stalled fetcher sees the pulse repeated every other cycle
        pb = pulse_cnt;
        repeat (6) begin
            @(negedge clk_in);
            #1;
        end
        check("stall_repeat", 32'(pulse_cnt - pb), 32'd3);
        idle();

        // Randomised fetch stream over a small, conflicting address pool
        for (int n = 0; n < 200; n++) begin
            mem_dly = $urandom_range(0, 4);
            if (n % 25 == 24) pc = 32'hFFFFFFFE;
            else pc = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 7)) << 2)
                      | (32'($urandom_range(0, 1)) << 1);
            fetch(pc);
            if ($urandom_range(0, 3) == 0) idle();
        end
        idle();
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
